// File: rtl/cacheline_burst_adaptor_if.sv
// Bundle of the cache-side pmem_* signals and the DRAM-side burst signals seen
// by cacheline_burst_adaptor. Signal names carry the adaptor's point of view.
// The slave modport is the adaptor; the master modport is the cache plus DRAM.
interface cacheline_burst_adaptor_if #(
  parameter int unsigned SLine  = 256,
  parameter int unsigned SBurst = 64
);
  // Cache side
  logic [SLine-1:0]  line_i;
  logic [SLine-1:0]  line_o;
  logic [31:0]       address_i;
  logic              read_i;
  logic              write_i;
  logic              resp_o;
  // DRAM side
  logic [SBurst-1:0] burst_i;
  logic [SBurst-1:0] burst_o;
  logic [31:0]       address_o;
  logic              read_o;
  logic              write_o;
  logic              resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_burst_adaptor.sv
// Cache-line to DRAM burst adaptor. Each line read/write from the cache becomes
// a NumBursts-beat burst; read beats are reassembled into line_o and a single
// resp_o pulse completes the transfer.
// Optional feature: define ADAPTOR_PERF_CNT_EN to add rd_count_o/wr_count_o
// completed-transaction counters.
module cacheline_burst_adaptor #(
  parameter int unsigned SLine     = 256,
  parameter int unsigned SBurst    = 64,
  parameter int unsigned SOffset   = 5,
  parameter int unsigned NumBursts = SLine / SBurst
) (
  input  logic                            clk,
  input  logic                            rst,
  cacheline_burst_adaptor_if.slave        bus
`ifdef ADAPTOR_PERF_CNT_EN
  ,
  output logic [31:0]                     rd_count_o,
  output logic [31:0]                     wr_count_o
`endif
);

  localparam int unsigned CntW = $clog2(NumBursts);
  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t LastBeat = cnt_t'(NumBursts - 1);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e           state_q, state_d;
  cnt_t             cnt_q, cnt_d;
  logic [SLine-1:0] line_q, line_d;
  logic [SLine-1:0] buf_q, buf_d;
  logic [31:0]      addr_q, addr_d;

  // State and datapath registers; reset clears everything, aborting any burst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      line_q  <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state: accept a request in idle, count beats, pulse done for one cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle: begin
        // Write has priority when both requests are high
        if (bus.write_i || bus.read_i) begin
          state_d = bus.write_i ? StWr : StRd;
          addr_d  = {bus.address_i[31:SOffset], {SOffset{1'b0}}};
          buf_d   = bus.line_i;
          cnt_d   = '0;
        end
      end
      StRd: begin
        if (bus.resp_i) begin
          line_d[SBurst*cnt_q +: SBurst] = bus.burst_i;
          cnt_d = cnt_t'(cnt_q + 1'b1);
          if (cnt_q == LastBeat) begin
            state_d = StDone;
          end
        end
      end
      StWr: begin
        if (bus.resp_i) begin
          cnt_d = cnt_t'(cnt_q + 1'b1);
          if (cnt_q == LastBeat) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decode directly from state so read_o/write_o drop as done is entered
  always_comb begin
    bus.line_o    = line_q;
    bus.address_o = addr_q;
    bus.read_o    = (state_q == StRd);
    bus.write_o   = (state_q == StWr);
    bus.resp_o    = (state_q == StDone);
    bus.burst_o   = '0;
    if (state_q == StWr) begin
      bus.burst_o = buf_q[SBurst*cnt_q +: SBurst];
    end
  end

`ifdef ADAPTOR_PERF_CNT_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  // Count completions on the cycle done is entered; natural 32-bit wrap
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (state_d == StDone && state_q == StRd) begin
      rd_cnt_d = rd_cnt_q + 32'd1;
    end
    if (state_d == StDone && state_q == StWr) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end
  end

  // Transaction counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_count_o = rd_cnt_q;
  assign wr_count_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Self-checking bench for cacheline_burst_adaptor. Expected lines/beats are
// queued when a request is issued and compared when the DUT produces them.
module tb_cacheline_burst_adaptor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cacheline_burst_adaptor_if bus ();

`ifdef ADAPTOR_PERF_CNT_EN
  logic [31:0] rd_count, wr_count;
`endif

  cacheline_burst_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ADAPTOR_PERF_CNT_EN
    ,
    .rd_count_o (rd_count),
    .wr_count_o (wr_count)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_resp_cyc = 0;
  int n_rd_done = 0;
  int n_wr_done = 0;
  bit resp_prev = 1'b0;

  bit           exp_kind_q[$];  // 0 = read, 1 = write
  logic [255:0] exp_line_q[$];
  logic [63:0]  exp_beat_q[$];
  logic [255:0] last_rd_line = '0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.write_o && exp_beat_q.size() != 0) begin
        if (bus.resp_i) check_eq("wr_beat", bus.burst_o, exp_beat_q.pop_front());
        else            check_eq("wr_beat_hold", bus.burst_o, exp_beat_q[0]);
      end
      if (bus.resp_o) begin
        check_eq("resp_single", resp_prev, 0);
        last_resp_cyc = cyc;
        check_eq("sb_nonempty", exp_kind_q.size() != 0, 1);
        if (exp_kind_q.size() != 0) begin
          if (exp_kind_q.pop_front() == 1'b0) begin
            logic [255:0] e;
            e = exp_line_q.pop_front();
            check_eq("rd_line", bus.line_o, e);
            last_rd_line = e;
            n_rd_done++;
          end else begin
            check_eq("wr_keeps_line", bus.line_o, last_rd_line);
            n_wr_done++;
          end
        end
      end
      resp_prev = bus.resp_o;
    end else begin
      resp_prev = 1'b0;
    end
  end

  // One cache transaction; pat gives resp_i per cycle (bit 0 first)
  task automatic xfer(input bit wr, input bit rd, input logic [31:0] addr,
                      input logic [255:0] data, input logic [15:0] pat, input bit b2b);
    int beat = 0;
    int c = 0;
    logic [31:0] aligned;
    aligned = addr & 32'hFFFF_FFE0;
    check_eq("idle_no_write", bus.write_o, 0);
    if (wr) begin
      exp_kind_q.push_back(1'b1);
      for (int i = 0; i < 4; i++) exp_beat_q.push_back(data[64*i +: 64]);
    end else begin
      exp_kind_q.push_back(1'b0);
      exp_line_q.push_back(data);
    end
    bus.read_i    = rd;
    bus.write_i   = wr;
    bus.address_i = addr;
    bus.line_i    = wr ? data : rand_line();
    @(posedge clk); #1;
    // Later input changes must be ignored
    bus.address_i = ~addr;
    bus.line_i    = ~bus.line_i;
    check_eq("addr_o", bus.address_o, aligned);
    check_eq("read_o", bus.read_o, rd && !wr);
    check_eq("write_o", bus.write_o, wr);
    if (b2b) check_eq("b2b_gap", cyc - last_resp_cyc, 2);
    while (beat < 4 && c < 16) begin
      bus.resp_i = pat[c];
      bus.burst_i = pat[c] ? data[64*beat +: 64] : {$urandom, $urandom};
      if (pat[c]) beat++;
      c++;
      @(posedge clk); #1;
    end
    check_eq("beats_done", beat, 4);
    bus.resp_i = 1'b0;
    check_eq("resp_o_done", bus.resp_o, 1);
    check_eq("read_o_done", bus.read_o, 0);
    check_eq("addr_o_held", bus.address_o, aligned);
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
    @(posedge clk); #1;
    check_eq("resp_o_idle", bus.resp_o, 0);
  endtask

  logic [255:0] rd_line0, wr_line0;

  initial begin
    bus.line_i = '0; bus.address_i = '0; bus.read_i = 1'b0; bus.write_i = 1'b0;
    bus.burst_i = '0; bus.resp_i = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_eq("rst_line_o", bus.line_o, 0);
    check_eq("rst_resp_o", bus.resp_o, 0);
    check_eq("rst_read_o", bus.read_o, 0);
    check_eq("rst_write_o", bus.write_o, 0);
    check_eq("rst_burst_o", bus.burst_o, 0);
    check_eq("rst_addr_o", bus.address_o, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Zero-gap read, then back-to-back write with gaps
    rd_line0 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    xfer(1'b0, 1'b1, 32'h0000_1234, rd_line0, 16'hFFFF, 1'b0);
    wr_line0 = 256'h0123456789abcdef_fedcba9876543210_0011223344556677_8899aabbccddeeff;
    xfer(1'b1, 1'b0, 32'h8000_00FF, wr_line0, 16'h0059, 1'b1);

    // Both requests high: write wins
    xfer(1'b1, 1'b1, $urandom, rand_line(), 16'hFFFF, 1'b0);

    // Reset mid-read after two beats
    bus.read_i = 1'b1;
    bus.address_i = 32'h0000_4040;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      bus.resp_i = 1'b1;
      bus.burst_i = {$urandom, $urandom} | 64'h1;
      @(posedge clk); #1;
    end
    bus.resp_i = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_read_o", bus.read_o, 0);
    check_eq("mid_rst_line_o", bus.line_o, 0);
    check_eq("mid_rst_addr_o", bus.address_o, 0);
    check_eq("mid_rst_resp_o", bus.resp_o, 0);
    bus.read_i = 1'b0;
    last_rd_line = '0;
    n_rd_done = 0;
    n_wr_done = 0;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("no_resp_after_rst", bus.resp_o, 0);
    end

    // Fresh read with gaps, then a short random mix
    xfer(1'b0, 1'b1, 32'h1234_5678, rand_line(), 16'hB5B5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bit w;
      w = i[0];
      xfer(w, !w, $urandom, rand_line(), 16'h0F0F | 16'($urandom), 1'b0);
    end
    check_eq("sb_drained", exp_kind_q.size() + exp_beat_q.size() + exp_line_q.size(), 0);

`ifdef ADAPTOR_PERF_CNT_EN
    check_eq("rd_count", rd_count, n_rd_done);
    check_eq("wr_count", wr_count, n_wr_done);
    force dut.rd_cnt_q = 32'hFFFF_FFFF;
    force dut.wr_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.rd_cnt_q;
    release dut.wr_cnt_q;
    xfer(1'b0, 1'b1, $urandom, rand_line(), 16'hFFFF, 1'b0);
    check_eq("rd_count_wrap", rd_count, 0);
    xfer(1'b1, 1'b0, $urandom, rand_line(), 16'hFFFF, 1'b0);
    check_eq("wr_count_wrap", wr_count, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
